output_layer_seq: RTL and testbench

//  Output-layer sequencer of the digit-recognition network, directly downstream of ram_hidden_unit.

---
 rtl/nn_pkg.sv | 18 +
 rtl/output_layer_seq_if.sv | 19 +
 rtl/mac_unit.sv | 20 ++
 rtl/output_layer_seq.sv | 76 +++++++
 tb/tb_output_layer_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared types, sizes and the clamp activation for the digit-recognition network.
package nn_pkg;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WR, DONE} state_t;
  localparam int DATA_WIDTH = 8;
  localparam int HID_ADDR_WIDTH = 5;
  localparam int OUT_ADDR_WIDTH = 4;
  localparam int ACC_WIDTH = 24;
  localparam int NUM_HIDDEN = 32;
  localparam int NUM_OUT = 10;
  localparam int ACT_SHIFT = 7;
  localparam int ACT_MAX = 255;
  // Negative sums clamp to 0; anything above the 8-bit window after the shift saturates.
  function automatic logic [DATA_WIDTH-1:0] act_clamp(input logic signed [ACC_WIDTH-1:0] a);
    return a[ACC_WIDTH-1] ? '0 :
           (|a[ACC_WIDTH-2:ACT_SHIFT+DATA_WIDTH]) ? DATA_WIDTH'(ACT_MAX) :
           a[ACT_SHIFT+DATA_WIDTH-1:ACT_SHIFT];
  endfunction
endpackage

// File: rtl/output_layer_seq_if.sv
// output_layer_seq_if: hidden-RAM, weight-ROM, output-RAM and control signals of the output layer.
interface output_layer_seq_if;
  import nn_pkg::*;
  logic start;
  logic [HID_ADDR_WIDTH-1:0] hid_addr;
  logic [DATA_WIDTH-1:0] hid_q;
  logic [OUT_ADDR_WIDTH+HID_ADDR_WIDTH-1:0] wt_addr;
  logic [DATA_WIDTH-1:0] wt_q;
  logic out_we;
  logic [OUT_ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic busy;
  logic done;
  logic [OUT_ADDR_WIDTH-1:0] digit;
  modport master (input start, hid_q, wt_q,
                  output hid_addr, wt_addr, out_we, out_addr, out_data, busy, done, digit);
  modport slave (output start, hid_q, wt_q,
                 input hid_addr, wt_addr, out_we, out_addr, out_data, busy, done, digit);
endinterface

// File: rtl/mac_unit.sv
// mac_unit: unsigned-activation by signed-weight multiply-accumulate with clear and enable.
module mac_unit #(
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DW-1:0]        a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);
  logic signed [2*DW:0] prod;
  assign prod = $signed({1'b0, a}) * b;
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + AW'(prod);
endmodule

// File: rtl/output_layer_seq.sv
// output_layer_seq: walks 10 neurons x 32 hidden inputs, clamps each sum, writes it out and tracks the argmax.
module output_layer_seq
  import nn_pkg::*;
(
  input logic clk,
  input logic rst,
  output_layer_seq_if.master bus
);
  state_t state, nxt;
  logic [HID_ADDR_WIDTH-1:0] h;
  logic [OUT_ADDR_WIDTH-1:0] o, best_idx;
  logic [DATA_WIDTH-1:0] best_val, act;
  logic mac_vld, h_last, o_last, better;
  logic signed [ACC_WIDTH-1:0] acc;
  assign h_last = h == HID_ADDR_WIDTH'(NUM_HIDDEN-1);
  assign o_last = o == OUT_ADDR_WIDTH'(NUM_OUT-1);
  assign act = act_clamp(acc);
  assign better = act > best_val;
  mac_unit #(.DW(DATA_WIDTH), .AW(ACC_WIDTH)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE || state == WR),
    .en(mac_vld),
    .a(bus.hid_q),
    .b($signed(bus.wt_q)),
    .acc(acc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = bus.start ? MAC : IDLE;
      MAC: nxt = h_last ? DRAIN : MAC;
      DRAIN: nxt = WR;
      WR: nxt = o_last ? DONE : MAC;
      default: nxt = IDLE;
    endcase
    bus.hid_addr = state == MAC ? h : '0;
    bus.wt_addr = state == MAC ? {o, h} : '0;
    bus.out_we = state == WR;
    bus.out_addr = state == WR ? o : '0;
    bus.out_data = state == WR ? act : '0;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // Read data lags the address by one cycle, so accumulation follows MAC by one cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h <= '0;
      o <= '0;
      mac_vld <= 1'b0;
      best_val <= '0;
      best_idx <= '0;
      bus.digit <= '0;
    end else begin
      mac_vld <= state == MAC;
      if (state == IDLE && bus.start) begin
        h <= '0;
        o <= '0;
        best_val <= '0;
        best_idx <= '0;
      end
      if (state == MAC) h <= h_last ? '0 : h + 1'b1;
      if (state == WR) begin
        h <= '0;
        if (better) begin
          best_val <= act;
          best_idx <= o;
        end
        if (o_last) bus.digit <= better ? o : best_idx;
        else o <= o + 1'b1;
      end
    end
endmodule

// File: tb/tb_output_layer_seq.sv
// tb_output_layer_seq: directed tests of the output-layer sequencer against registered RAM/ROM models.
module tb_output_layer_seq;
  import nn_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  output_layer_seq_if bus();
  output_layer_seq dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [7:0] hid_mem [32];
  logic [7:0] wt_mem [512];
  always @(posedge clk) begin
    bus.hid_q <= hid_mem[bus.hid_addr];
    bus.wt_q <= wt_mem[bus.wt_addr];
  end

  int cyc = 0, t0 = 0, nwr = 0, ndone = 0, first_we = -1, done_rel = -1;
  int checks = 0, errors = 0;
  logic [3:0] wr_addr [16];
  logic [7:0] wr_data [16];
  logic [3:0] digit_at_done;
  bit timed_out;
  logic [7:0] exp_ramp [10] = '{8'd0, 8'd32, 8'd64, 8'd96, 8'd128, 8'd160, 8'd192, 8'd224, 8'd255, 8'd255};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.out_we) begin
      if (nwr < 16) begin
        wr_addr[nwr] = bus.out_addr;
        wr_data[nwr] = bus.out_data;
      end
      if (nwr == 0) first_we = cyc - t0;
      nwr++;
    end
    if (bus.done) begin
      ndone++;
      done_rel = cyc - t0;
      digit_at_done = bus.digit;
    end
  end

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) hid_mem[i] = 8'h80;
    for (int i = 0; i < 512; i++) wt_mem[i] = 8'(i / 32);
  endtask

  // Pulses start, then waits for done; abort_at >= 0 returns early at that relative cycle.
  task automatic run(input int abort_at, input bit repulse);
    int rel;
    nwr = 0; ndone = 0; first_we = -1; done_rel = -1; timed_out = 0; digit_at_done = 'x;
    for (int i = 0; i < 16; i++) begin wr_addr[i] = 'x; wr_data[i] = 'x; end
    @(negedge clk); #1;
    bus.start = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 400 && ndone == 0; i++) begin
      @(negedge clk); #1;
      rel = cyc - t0;
      bus.start = repulse && (rel == 50 || rel == 200);
      if (rel == abort_at) return;
    end
    bus.start = 1'b0;
    timed_out = ndone == 0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL reset_out_we: got %b want 0", bus.out_we); end
    checks++; if (bus.digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", bus.digit); end
    checks++; if (bus.hid_addr !== 5'd0 || bus.wt_addr !== 9'd0) begin errors++; $display("FAIL reset_addr: got hid %0d wt %0d want 0 0", bus.hid_addr, bus.wt_addr); end
    checks++; if (bus.out_addr !== 4'd0 || bus.out_data !== 8'd0) begin errors++; $display("FAIL reset_out: got addr %0d data %0d want 0 0", bus.out_addr, bus.out_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    load_ramp();
    run(-1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL ramp_timeout: got no done want done"); end
    checks++; if (nwr != 10) begin errors++; $display("FAIL ramp_nwr: got %0d want 10", nwr); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== exp_ramp[i]) begin
        errors++; $display("FAIL ramp_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, wr_addr[i], wr_data[i], i, exp_ramp[i]);
      end
    end
    checks++; if (digit_at_done !== 4'd8) begin errors++; $display("FAIL ramp_digit_at_done: got %0d want 8", digit_at_done); end
    checks++; if (bus.digit !== 4'd8) begin errors++; $display("FAIL ramp_digit_held: got %0d want 8", bus.digit); end
  endtask

  task automatic test_latency();
    load_ramp();
    run(-1, 1'b0);
    checks++; if (first_we != 33) begin errors++; $display("FAIL lat_first_we: got %0d want 33", first_we); end
    checks++; if (done_rel != 340) begin errors++; $display("FAIL lat_done: got %0d want 340", done_rel); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL lat_done_width: got %0d want 1", ndone); end
    checks++; if (nwr != 10) begin errors++; $display("FAIL lat_nwr: got %0d want 10", nwr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lat_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 32; i++) hid_mem[i] = 8'hFF;
    for (int i = 0; i < 512; i++) wt_mem[i] = 8'hFF;
    run(-1, 1'b0);
    checks++; if (nwr != 10) begin errors++; $display("FAIL neg_nwr: got %0d want 10", nwr); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== 8'd0) begin
        errors++; $display("FAIL neg_wr%0d: got addr %0d data %0d want addr %0d data 0", i, wr_addr[i], wr_data[i], i);
      end
    end
    checks++; if (digit_at_done !== 4'd0) begin errors++; $display("FAIL neg_digit: got %0d want 0", digit_at_done); end
  endtask

  task automatic test_one_hot();
    for (int i = 0; i < 32; i++) hid_mem[i] = 8'h00;
    for (int i = 0; i < 512; i++) wt_mem[i] = 8'h00;
    hid_mem[17] = 8'hC8;
    wt_mem[3*32+17] = 8'h7F;
    run(-1, 1'b0);
    checks++; if (nwr != 10) begin errors++; $display("FAIL hot_nwr: got %0d want 10", nwr); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== (i == 3 ? 8'd198 : 8'd0)) begin
        errors++; $display("FAIL hot_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, wr_addr[i], wr_data[i], i, i == 3 ? 198 : 0);
      end
    end
    checks++; if (digit_at_done !== 4'd3) begin errors++; $display("FAIL hot_digit: got %0d want 3", digit_at_done); end
  endtask

  task automatic test_repulse();
    load_ramp();
    run(-1, 1'b1);
    checks++; if (ndone != 1 || done_rel != 340) begin errors++; $display("FAIL repulse_done: got %0d dones at %0d want 1 at 340", ndone, done_rel); end
    checks++; if (nwr != 10) begin errors++; $display("FAIL repulse_nwr: got %0d want 10", nwr); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== exp_ramp[i]) begin
        errors++; $display("FAIL repulse_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, wr_addr[i], wr_data[i], i, exp_ramp[i]);
      end
    end
    checks++; if (digit_at_done !== 4'd8) begin errors++; $display("FAIL repulse_digit: got %0d want 8", digit_at_done); end
  endtask

  task automatic test_reset_midrun();
    load_ramp();
    run(100, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL abort_out_we: got %b want 0", bus.out_we); end
    checks++; if (bus.digit !== 4'd0) begin errors++; $display("FAIL abort_digit: got %0d want 0", bus.digit); end
    nwr = 0; ndone = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    #1;
    checks++; if (nwr != 0 || ndone != 0) begin errors++; $display("FAIL abort_quiet: got %0d writes %0d dones want 0 0", nwr, ndone); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b want 0", bus.busy); end
    run(-1, 1'b0);
    checks++; if (ndone != 1 || done_rel != 340) begin errors++; $display("FAIL restart_done: got %0d dones at %0d want 1 at 340", ndone, done_rel); end
    checks++; if (nwr != 10) begin errors++; $display("FAIL restart_nwr: got %0d want 10", nwr); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== exp_ramp[i]) begin
        errors++; $display("FAIL restart_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, wr_addr[i], wr_data[i], i, exp_ramp[i]);
      end
    end
    checks++; if (digit_at_done !== 4'd8) begin errors++; $display("FAIL restart_digit: got %0d want 8", digit_at_done); end
  endtask

  initial begin
    bus.start = 1'b0;
    load_ramp();
    test_reset();
    test_ramp();
    test_latency();
    test_negative();
    test_one_hot();
    test_repulse();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
